passcode_digit_entry: RTL and testbench

Sequential front end of the passcode display path. It collects up to four debounced keypad digits and stores them in a 4-digit display buffer. It checks the entry against a parameterised passcode and tracks failed attempts, with a lockout after too many failures. It drives four 4-bit nibbles, one per digit, straight into the team's 4-bit-to-seven-segment decoders, which decode 4'hF to all segments off and 4'hE to "E".

---
 rtl/passcode_digit_entry_pkg.sv | 6 +
 rtl/passcode_digit_shiftreg.sv | 29 ++
 rtl/passcode_digit_entry.sv | 96 +++++++++
 tb/tb_passcode_digit_entry.sv | 135 +++++++++++++
 4 files changed

// File: rtl/passcode_digit_entry_pkg.sv
// passcode_digit_entry_pkg: shared state encoding and display nibble constants
package passcode_digit_entry_pkg;
  typedef enum logic [1:0] {ENTRY, GRANTED, DENIED, LOCKED} state_t;
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] ERR = 4'hE;
endpackage

// File: rtl/passcode_digit_shiftreg.sv
// passcode_digit_shiftreg: 4-nibble left-shift display buffer with digit count
module passcode_digit_shiftreg
  import passcode_digit_entry_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [3:0]  i_load_val,
  input  logic        i_shift,
  input  logic [3:0]  i_digit,
  output logic [15:0] o_disp,
  output logic [2:0]  o_count
);
  logic [15:0] r_disp;
  logic [2:0]  r_count;
  always_ff @(posedge Clk)
    if (!Rst || i_clear) begin
      r_disp  <= {4{BLANK}};
      r_count <= '0;
    end else if (i_load)
      r_disp <= {4{i_load_val}};
    else if (i_shift && r_count < 3'd4) begin
      r_disp  <= {r_disp[11:0], i_digit};
      r_count <= r_count + 3'd1;
    end
  assign o_disp  = r_disp;
  assign o_count = r_count;
endmodule

// File: rtl/passcode_digit_entry.sv
// passcode_digit_entry: keypad entry FSM with passcode check, failure count and lockout
module passcode_digit_entry
  import passcode_digit_entry_pkg::*;
#(
  parameter logic [15:0] PASSCODE    = 16'h1234,
  parameter int          HOLD_CYCLES = 50_000_000,
  parameter int          LOCK_CYCLES = 500_000_000,
  parameter int          MAX_TRIES   = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Digit_in,
  input  logic       Digit_valid,
  input  logic       Clear_in,
  input  logic       Enter_in,
  output logic [3:0] Disp3,
  output logic [3:0] Disp2,
  output logic [3:0] Disp1,
  output logic [3:0] Disp0,
  output logic       Access_granted,
  output logic       Locked,
  output logic [2:0] Fail_count
);
  localparam int TW = $clog2(LOCK_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
  localparam logic [2:0] MAX_FAIL = 3'(MAX_TRIES);
  state_t        r_state, w_next;
  logic [TW-1:0] r_timer, w_timer;
  logic [2:0]    r_fail, w_fail;
  logic          r_granted, r_locked;
  logic          w_clear, w_load, w_shift;
  logic [15:0]   w_disp;
  logic [2:0]    w_count;
  passcode_digit_shiftreg u_buf (
    .Clk(Clk), .Rst(Rst), .i_clear(w_clear), .i_load(w_load), .i_load_val(ERR),
    .i_shift(w_shift), .i_digit(Digit_in), .o_disp(w_disp), .o_count(w_count)
  );
  always_comb begin
    w_next  = r_state;
    w_fail  = r_fail;
    w_clear = 1'b0;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ENTRY:
        if (Clear_in) w_clear = 1'b1;
        else if (Enter_in) begin
          if (w_count == 3'd4 && w_disp == PASSCODE) begin
            w_next = GRANTED;
            w_fail = '0;
          end else if (w_count == 3'd4) begin
            w_next = DENIED;
            w_load = 1'b1;
            w_fail = (r_fail == MAX_FAIL) ? r_fail : r_fail + 3'd1;
          end
        end else w_shift = Digit_valid && Digit_in <= 4'd9;
      GRANTED:
        if (r_timer == HOLD_LAST) begin
          w_next  = ENTRY;
          w_clear = 1'b1;
        end
      DENIED:
        if (r_timer == HOLD_LAST) begin
          w_next  = (r_fail == MAX_FAIL) ? LOCKED : ENTRY;
          w_clear = r_fail != MAX_FAIL;
        end
      default:
        if (r_timer == LOCK_LAST) begin
          w_next  = ENTRY;
          w_clear = 1'b1;
          w_fail  = '0;
        end
    endcase
    // timer restarts on every state change and idles at zero in ENTRY
    w_timer = (w_next == r_state && r_state != ENTRY) ? r_timer + 1'b1 : '0;
  end
  always_ff @(posedge Clk)
    if (!Rst) begin
      r_state   <= ENTRY;
      r_timer   <= '0;
      r_fail    <= '0;
      r_granted <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timer   <= w_timer;
      r_fail    <= w_fail;
      r_granted <= w_next == GRANTED;
      r_locked  <= w_next == LOCKED;
    end
  assign {Disp3, Disp2, Disp1, Disp0} = w_disp;
  assign Access_granted = r_granted;
  assign Locked         = r_locked;
  assign Fail_count     = r_fail;
endmodule

// File: tb/tb_passcode_digit_entry.sv
// tb_passcode_digit_entry: scoreboard bench with a digit-list reference model
module tb_passcode_digit_entry;
  localparam logic [15:0] PASS = 16'h6728;
  localparam int HOLD = 4;
  localparam int LOCK = 8;
  localparam int MAXT = 3;
  logic       Clk = 1'b0, Rst = 1'b0, Digit_valid = 1'b0, Clear_in = 1'b0, Enter_in = 1'b0;
  logic [3:0] Digit_in = 4'd0;
  logic [3:0] Disp3, Disp2, Disp1, Disp0;
  logic       Access_granted, Locked;
  logic [2:0] Fail_count;
  int checks = 0, errors = 0;
  logic [20:0] exp_q[$];
  logic [20:0] mon_e, mon_a;
  int m_mode = 0, m_left = 0, m_fails = 0;
  int m_digs[$];

  passcode_digit_entry #(.PASSCODE(PASS), .HOLD_CYCLES(HOLD), .LOCK_CYCLES(LOCK), .MAX_TRIES(MAXT)) dut (
    .Clk(Clk), .Rst(Rst), .Digit_in(Digit_in), .Digit_valid(Digit_valid), .Clear_in(Clear_in),
    .Enter_in(Enter_in), .Disp3(Disp3), .Disp2(Disp2), .Disp1(Disp1), .Disp0(Disp0),
    .Access_granted(Access_granted), .Locked(Locked), .Fail_count(Fail_count)
  );

  always #5 Clk = ~Clk;

  // mode: 0 entry, 1 granted, 2 denied, 3 locked; m_left counts remaining hold cycles
  function automatic logic [20:0] expect_now();
    logic [15:0] d;
    int n;
    n = m_digs.size();
    for (int k = 0; k < 4; k++)
      d[k*4 +: 4] = (m_mode >= 2) ? 4'hE : (k < n) ? 4'(m_digs[n-1-k]) : 4'hF;
    return {d, m_mode == 1, m_mode == 3, 3'(m_fails)};
  endfunction

  task automatic model(input logic rst, input logic dv, input logic [3:0] d, input logic clr, input logic ent);
    int code;
    if (!rst) begin
      m_mode = 0; m_left = 0; m_fails = 0; m_digs.delete();
    end else if (m_mode == 0) begin
      if (clr) m_digs.delete();
      else if (ent) begin
        if (m_digs.size() == 4) begin
          code = 0;
          foreach (m_digs[i]) code = code * 16 + m_digs[i];
          m_left = HOLD;
          if (code == int'(PASS)) begin m_mode = 1; m_fails = 0; end
          else begin m_mode = 2; m_fails = (m_fails + 1 > MAXT) ? MAXT : m_fails + 1; end
        end
      end else if (dv && d <= 9 && m_digs.size() < 4) m_digs.push_back(int'(d));
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_mode == 2 && m_fails == MAXT) begin m_mode = 3; m_left = LOCK; end
        else begin
          if (m_mode == 3) m_fails = 0;
          m_mode = 0;
          m_digs.delete();
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic dv, input logic [3:0] d, input logic clr, input logic ent);
    Rst = rst; Digit_valid = dv; Digit_in = d; Clear_in = clr; Enter_in = ent;
    @(posedge Clk);
    model(rst, dv, d, clr, ent);
    exp_q.push_back(expect_now());
    #1;
  endtask

  task automatic dig(input int v); step(1'b1, 1'b1, 4'(v), 1'b0, 1'b0); endtask
  task automatic idle(input int n); repeat (n) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0); endtask
  task automatic ent(); step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1); endtask
  task automatic attempt(input int a, input int b, input int c, input int e);
    dig(a); dig(b); dig(c); dig(e); ent();
  endtask

  always @(negedge Clk)
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {Disp3, Disp2, Disp1, Disp0, Access_granted, Locked, Fail_count};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL outputs t=%0t got disp=%h g=%b l=%b f=%0d exp disp=%h g=%b l=%b f=%0d", $time,
                 mon_a[20:5], mon_a[4], mon_a[3], mon_a[2:0], mon_e[20:5], mon_e[4], mon_e[3], mon_e[2:0]);
      end
    end

  initial begin
    int r, pos;
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    attempt(6, 7, 2, 8); idle(6);
    attempt(6, 7, 2, 9); idle(6);
    dig(1); dig(2); ent(); idle(2);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    attempt(1, 1, 1, 1); idle(5);
    attempt(2, 2, 2, 2); idle(5);
    for (int i = 0; i < 6; i++) dig(i);
    idle(8);
    attempt(1, 2, 3, 4); dig(5); dig(11); idle(1);
    step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    dig(9); dig(15); idle(1);
    attempt(6, 7, 2, 8); idle(2);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(1);
    attempt(0, 0, 0, 0); idle(5);
    attempt(0, 0, 0, 0); idle(5);
    attempt(0, 0, 0, 0); idle(7);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      pos = m_digs.size() % 4;
      if (r < 2) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      else if (r < 6) step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      else if (r < 16) step(1'b1, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
      else if (r < 60) begin
        if ($urandom_range(0, 3) == 0) dig(int'($urandom_range(0, 15)));
        else dig(int'(PASS[(3-pos)*4 +: 4]));
      end else idle(1);
    end
    idle(2);
    repeat (2) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
